// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multi-cycle control unit: opcodes, datapath
// select encodings, the state enum seen on the debug port, and the control bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_EXEC     = 4'd7,
    S_R_WB     = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_ADDI_EX  = 4'd11,
    S_ADDI_WB  = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational state-to-control decoder. Only FETCH (mem_ready gating of the
// writes) and DECODE (illegal opcode flag) look at anything besides the state.
module mips_ctrl_decode
  import mips_pkg::*;
(
  input  state_e     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.i_or_d    = 1'b0;
        ctrl.alu_src_a = 1'b0;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PC_ALU;
        // PC+4 and IR load only land on the cycle memory delivers the word
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_a  = 1'b0;
        ctrl.alu_src_b  = SRCB_IMM_SH;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = !op_supported(opcode);
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      S_MEM_WR: begin
        ctrl.mem_write = 1'b1;
        ctrl.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_B;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
      end
      S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_ADDI_WB: begin
        ctrl.reg_dst    = 1'b0;
        ctrl.mem_to_reg = 1'b0;
        ctrl.reg_write  = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// MIPS multi-cycle control unit: state register and next-state logic; the
// control outputs come from the mips_ctrl_decode instance.
module mips_multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RST;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_RST:      state_d = S_FETCH;
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      // Only LW/SW reach here; anything else (IR corrupted) recovers via FETCH
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_FETCH;
      end
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_EXEC:     state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_ADDI_EX:  state_d = S_ADDI_WB;
      S_ADDI_WB:  state_d = S_FETCH;
      default:    state_d = S_RST;
    endcase
  end

  mips_ctrl_decode u_decode (
    .state     (state_q),
    .opcode    (opcode),
    .mem_ready (mem_ready),
    .ctrl      (ctrl)
  );

  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign i_or_d        = ctrl.i_or_d;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = ctrl.illegal_op;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: per-cycle control vectors from a table of
// instruction phases, random opcode mix and random memory wait lengths.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int rw_cnt;
  logic [3:0] dbg_rst, dbg_fetch;

  mips_multicycle_control dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aop, psrc, ill}
  logic [16:0] obs;
  assign obs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                pc_source, illegal_op};

  function automatic logic [16:0] v(
    input logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca,
    input logic [1:0] srcb, aop, psrc, input logic ill);
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, srca, srcb, aop, psrc, ill};
  endfunction

  //                     pcw  pcwc iord mrd mwr irw m2r rdst rwr srca srcb  aop   psrc  ill
  wire [16:0] E_ZERO   = v(0, 0,   0,   0,  0,  0,  0,  0,   0,  0,   2'b00,2'b00,2'b00,0);
  wire [16:0] E_FWAIT  = v(0, 0,   0,   1,  0,  0,  0,  0,   0,  0,   2'b01,2'b00,2'b00,0);
  wire [16:0] E_FDONE  = v(1, 0,   0,   1,  0,  1,  0,  0,   0,  0,   2'b01,2'b00,2'b00,0);
  wire [16:0] E_DEC    = v(0, 0,   0,   0,  0,  0,  0,  0,   0,  0,   2'b11,2'b00,2'b00,0);
  wire [16:0] E_DECILL = v(0, 0,   0,   0,  0,  0,  0,  0,   0,  0,   2'b11,2'b00,2'b00,1);
  wire [16:0] E_MADDR  = v(0, 0,   0,   0,  0,  0,  0,  0,   0,  1,   2'b10,2'b00,2'b00,0);
  wire [16:0] E_MRD    = v(0, 0,   1,   1,  0,  0,  0,  0,   0,  0,   2'b00,2'b00,2'b00,0);
  wire [16:0] E_MWB    = v(0, 0,   0,   0,  0,  0,  1,  0,   1,  0,   2'b00,2'b00,2'b00,0);
  wire [16:0] E_MWR    = v(0, 0,   1,   0,  1,  0,  0,  0,   0,  0,   2'b00,2'b00,2'b00,0);
  wire [16:0] E_EXEC   = v(0, 0,   0,   0,  0,  0,  0,  0,   0,  1,   2'b00,2'b10,2'b00,0);
  wire [16:0] E_RWB    = v(0, 0,   0,   0,  0,  0,  0,  1,   1,  0,   2'b00,2'b00,2'b00,0);
  wire [16:0] E_BR     = v(0, 1,   0,   0,  0,  0,  0,  0,   0,  1,   2'b00,2'b01,2'b01,0);
  wire [16:0] E_JMP    = v(1, 0,   0,   0,  0,  0,  0,  0,   0,  0,   2'b00,2'b00,2'b10,0);
  wire [16:0] E_AEX    = v(0, 0,   0,   0,  0,  0,  0,  0,   0,  1,   2'b10,2'b00,2'b00,0);
  wire [16:0] E_AWB    = v(0, 0,   0,   0,  0,  0,  0,  0,   1,  0,   2'b00,2'b00,2'b00,0);

  task automatic chk(input string tag, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_dbg(input string tag, input logic [3:0] exp);
    checks++;
    assert (state_dbg === exp) else begin
      errors++;
      $error("FAIL %s state_dbg=%0d expected=%0d", tag, state_dbg, exp);
    end
  endtask

  // One clock: drive, let combinational outputs settle, compare, advance.
  task automatic cyc(input logic [5:0] op, input logic mr, input logic [16:0] exp,
                     input string tag);
    opcode    = op;
    mem_ready = mr;
    #3;
    chk(tag, exp);
    rw_cnt += int'(reg_write);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] illegal_opcode();
    logic [5:0] o;
    do o = 6'($urandom);
    while (o == 6'b000000 || o == 6'b100011 || o == 6'b101011 ||
           o == 6'b000100 || o == 6'b000010 || o == 6'b001000);
    return o;
  endfunction

  // Runs one instruction from FETCH; fw/mw are wait cycles in fetch / data memory.
  task automatic run(input logic [5:0] op, input int fw, input int mw, input string tag);
    int exp_rw;
    rw_cnt = 0;
    for (int i = 0; i < fw; i++) cyc(6'($urandom), 1'b0, E_FWAIT, {tag, "/fetch_wait"});
    cyc(6'($urandom), 1'b1, E_FDONE, {tag, "/fetch"});
    exp_rw = 0;
    case (op)
      6'b100011: begin
        cyc(op, 1'($urandom), E_DEC, {tag, "/decode"});
        cyc(op, 1'($urandom), E_MADDR, {tag, "/maddr"});
        for (int i = 0; i < mw; i++) cyc(op, 1'b0, E_MRD, {tag, "/mrd_wait"});
        cyc(op, 1'b1, E_MRD, {tag, "/mrd"});
        cyc(op, 1'($urandom), E_MWB, {tag, "/mwb"});
        exp_rw = 1;
      end
      6'b101011: begin
        cyc(op, 1'($urandom), E_DEC, {tag, "/decode"});
        cyc(op, 1'($urandom), E_MADDR, {tag, "/maddr"});
        for (int i = 0; i < mw; i++) cyc(op, 1'b0, E_MWR, {tag, "/mwr_wait"});
        cyc(op, 1'b1, E_MWR, {tag, "/mwr"});
      end
      6'b000000: begin
        cyc(op, 1'($urandom), E_DEC, {tag, "/decode"});
        cyc(op, 1'($urandom), E_EXEC, {tag, "/exec"});
        cyc(op, 1'($urandom), E_RWB, {tag, "/rwb"});
        exp_rw = 1;
      end
      6'b000100: begin
        cyc(op, 1'($urandom), E_DEC, {tag, "/decode"});
        cyc(op, 1'($urandom), E_BR, {tag, "/branch"});
      end
      6'b000010: begin
        cyc(op, 1'($urandom), E_DEC, {tag, "/decode"});
        cyc(op, 1'($urandom), E_JMP, {tag, "/jump"});
      end
      6'b001000: begin
        cyc(op, 1'($urandom), E_DEC, {tag, "/decode"});
        cyc(op, 1'($urandom), E_AEX, {tag, "/addi_ex"});
        cyc(op, 1'($urandom), E_AWB, {tag, "/addi_wb"});
        exp_rw = 1;
      end
      default: cyc(op, 1'($urandom), E_DECILL, {tag, "/decode_illegal"});
    endcase
    checks++;
    assert (rw_cnt == exp_rw) else begin
      errors++;
      $error("FAIL %s/reg_write_count observed=%0d expected=%0d", tag, rw_cnt, exp_rw);
    end
    // Instruction length: must be back in FETCH exactly here.
    chk_dbg({tag, "/back_to_fetch"}, dbg_fetch);
  endtask

  logic [5:0] ops [6];

  initial begin
    ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
    ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
    rst = 1'b1; opcode = '0; mem_ready = 1'b1;

    @(posedge clk); #1;
    #3 chk("reset_cycle1", E_ZERO);
    @(posedge clk); #1;
    #3 chk("reset_cycle2", E_ZERO);
    dbg_rst = state_dbg;
    rst = 1'b0;
    #1 chk("rst_state_after_release", E_ZERO);
    @(posedge clk); #1;
    checks++;
    assert (state_dbg !== dbg_rst) else begin
      errors++;
      $error("FAIL rst_to_fetch state_dbg=%0d expected!=%0d", state_dbg, dbg_rst);
    end
    dbg_fetch = state_dbg;

    run(6'b000000, 0, 0, "rtype");
    run(6'b100011, 0, 3, "lw_wait3");
    run(6'b000100, 0, 0, "beq");
    run(6'b000010, 0, 0, "j");
    run(6'b111111, 0, 0, "illegal_3f");
    run(6'b101011, 2, 1, "sw_waits");
    run(6'b001000, 1, 0, "addi");

    for (int n = 0; n < 40; n++) begin
      logic [5:0] op;
      if ($urandom_range(0, 7) == 0) op = illegal_opcode();
      else                           op = ops[$urandom_range(0, 5)];
      run(op, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    // Reset while SW is stalled in the memory write.
    cyc(6'($urandom), 1'b1, E_FDONE, "rstwr/fetch");
    cyc(6'b101011, 1'b0, E_DEC, "rstwr/decode");
    cyc(6'b101011, 1'b0, E_MADDR, "rstwr/maddr");
    cyc(6'b101011, 1'b0, E_MWR, "rstwr/mwr_wait");
    rst = 1'b1;
    cyc(6'b101011, 1'b0, E_MWR, "rstwr/mwr_at_rst");
    rst = 1'b0;
    cyc(6'b101011, 1'b1, E_ZERO, "rstwr/rst_state");
    chk_dbg("rstwr/fetch_resumes", dbg_fetch);
    run(6'b000000, 0, 0, "rstwr/rtype_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
